// File: rtl/uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm
//
// Frame controller for the UART transmit path. Takes a byte handshake from
// the upstream host, drives the serializer enable, and builds the line-level
// frame (start bit, 8 data bits LSB first, optional parity, 1 or 2 stop
// bits) on the serial output.
//
// Parameters:
//   STOP_BITS  : stop-bit cycles per frame (1 or 2; other values act as the
//                nearest legal value).
//
// Ports:
//   clk        in   bit clock, one serial bit per cycle
//   rst        in   synchronous active-low reset
//   P_DATA     in   [7:0] byte to transmit, latched on acceptance
//   Data_Valid in   send request (pulse or level)
//   PAR_EN     in   1 = append a parity bit, latched on acceptance
//   PAR_TYP    in   0 = even, 1 = odd parity, latched on acceptance
//   ser_done   in   serializer is presenting the 8th data bit
//   ser_data   in   current data bit from the serializer
//   ser_en     out  serializer enable (low = load, high = shift)
//   TX_OUT     out  serial line, idles high
//   busy       out  frame in progress
// ---------------------------------------------------------------------------
module uart_tx_fsm #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic       ser_done,
    input  logic       ser_data,
    output logic       ser_en,
    output logic       TX_OUT,
    output logic       busy
);

    // State encodings; any other value is treated as illegal and recovers
    // to IDLE on the next edge.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // The stop counter only needs to distinguish the first and second stop
    // cycle; value of the counter on the final stop cycle.
    localparam logic STOP_LAST = (STOP_BITS >= 2) ? 1'b1 : 1'b0;

    // Parity over a byte: even parity is the XOR of the bits, odd parity
    // is its complement.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    logic [2:0] r_state;
    logic [7:0] r_data;
    logic       r_par_en;
    logic       r_par_typ;
    logic       r_stop_cnt;
    logic       r_ser_en;
    logic       r_busy;
    logic       r_tx_fix;

    logic [2:0] w_state_nxt;
    logic [7:0] w_data_nxt;
    logic       w_par_en_nxt;
    logic       w_par_typ_nxt;
    logic       w_stop_cnt_nxt;
    logic       w_stop_last;
    logic       w_accept;
    logic       w_ser_en_nxt;
    logic       w_busy_nxt;
    logic       w_tx_fix_nxt;

    assign w_stop_last = (r_stop_cnt == STOP_LAST);

    // A request is taken only in IDLE or on the last stop cycle; everywhere
    // else Data_Valid is simply ignored.
    assign w_accept = Data_Valid &&
                      ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_stop_last));

    // Next-state and frame-parameter latch logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_stop_cnt_nxt = r_stop_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                // ser_done marks the 8th data bit on the line.
                if (ser_done) begin
                    if (r_par_en) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_state_nxt    = ST_STOP;
                        w_stop_cnt_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                w_state_nxt    = ST_STOP;
                w_stop_cnt_nxt = 1'b0;
            end
            ST_STOP: begin
                if (w_stop_last) begin
                    w_stop_cnt_nxt = 1'b0;
                    if (w_accept) begin
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt    = ST_STOP;
                    w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_stop_cnt_nxt = 1'b0;
            end
        endcase

        if (w_accept) begin
            w_data_nxt    = P_DATA;
            w_par_en_nxt  = PAR_EN;
            w_par_typ_nxt = PAR_TYP;
        end else begin
            w_data_nxt    = r_data;
            w_par_en_nxt  = r_par_en;
            w_par_typ_nxt = r_par_typ;
        end
    end

    // Output values for the state being entered, so the output flops hold
    // a clean Moore decode of the registered state.
    always_comb begin
        w_ser_en_nxt = (w_state_nxt == ST_START) || (w_state_nxt == ST_DATA);
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        case (w_state_nxt)
            ST_IDLE:   w_tx_fix_nxt = 1'b1;
            ST_START:  w_tx_fix_nxt = 1'b0;
            ST_DATA:   w_tx_fix_nxt = 1'b1;
            ST_PARITY: w_tx_fix_nxt = parity_bit(w_data_nxt, w_par_typ_nxt);
            ST_STOP:   w_tx_fix_nxt = 1'b1;
            default:   w_tx_fix_nxt = 1'b1;
        endcase
    end

    // State, latched frame parameters and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_data     <= 8'h00;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_ser_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_fix   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_typ  <= w_par_typ_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_ser_en   <= w_ser_en_nxt;
            r_busy     <= w_busy_nxt;
            r_tx_fix   <= w_tx_fix_nxt;
        end
    end

    // Data bits come straight from the serializer's own register; every
    // other bit of the frame comes from the fixed-value flop.
    assign TX_OUT = (r_state == ST_DATA) ? ser_data : r_tx_fix;
    assign ser_en = r_ser_en;
    assign busy   = r_busy;

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
Frame controller for the UART transmit path. It accepts a byte handshake from the upstream host and drives the serializer's `ser_en`. It consumes `ser_done` and `ser_data` from the serializer. It generates start, parity and stop bits and muxes everything onto the serial line `TX_OUT`. It sits directly downstream of the serializer and owns the line-level frame format.

Parameters:
STOP_BITS, 1, number of stop-bit cycles per frame; legal values 1 or 2.

Ports:
clk  input  1  bit clock; one serial bit per cycle.
rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
P_DATA  input  8  byte to transmit; sampled for parity on acceptance.
Data_Valid  input  1  request to send P_DATA; single-cycle or level.
PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
ser_done  input  1  serializer has presented the 8th data bit (counter==8).
ser_data  input  1  current data bit from the serializer (registered, LSB first).
ser_en  output  1  serializer enable; low loads P_DATA into the serializer, high shifts.
TX_OUT  output  1  serial line; idles high.
busy  output  1  frame in progress; high in every state except IDLE.

Behaviour:
- Reset (rst==0 at a clk edge): state = IDLE; latched data/PAR_EN/PAR_TYP/stop counter = 0. Following that edge: TX_OUT=1, ser_en=0, busy=0.
- Reset mid-frame aborts the frame immediately; no stop bit is emitted.
- States: IDLE, START, DATA, PARITY, STOP. State is registered; all outputs are Moore decodes of state plus the registers listed, except TX_OUT in DATA, which passes ser_data straight through.
- Acceptance: at an edge where state is IDLE, or the final STOP cycle, and Data_Valid==1:
  - latch P_DATA, PAR_EN and PAR_TYP;
  - go to START.
  - The serializer loads P_DATA on this same edge because ser_en==0; upstream must hold P_DATA valid while Data_Valid is high.
- Data_Valid is ignored in START, DATA, PARITY and non-final STOP cycles; no queuing, no error flag.
- IDLE: TX_OUT=1, ser_en=0, busy=0. Stays in IDLE until acceptance.
- START: exactly 1 cycle. TX_OUT=0, ser_en=1, busy=1. The serializer shifts bit0 into ser_data at the exiting edge. Next state is DATA.
- DATA: TX_OUT=ser_data, ser_en=1, busy=1.
  - DATA cycle k (k=1..8) shows data bit k-1.
  - ser_done rises in cycle 8. On that edge, go to PARITY if latched PAR_EN==1, else STOP.
  - DATA always lasts exactly 8 cycles.
- PARITY: 1 cycle. ser_en=0, busy=1.
  - TX_OUT = ^data_latched when PAR_TYP==0 (even).
  - TX_OUT = ~^data_latched when PAR_TYP==1 (odd).
  - Next state is STOP.
- STOP: STOP_BITS cycles, counted by an internal counter cleared on entry. TX_OUT=1, ser_en=0, busy=1.
  - On the final STOP cycle, acceptance goes to START (back-to-back, no idle gap).
  - Otherwise the final STOP cycle goes to IDLE.
- Frame length in cycles = 1 + 8 + PAR_EN + STOP_BITS (10, 11, 11 or 12).
- ser_done outside DATA is ignored.
- A change of PAR_EN, PAR_TYP or P_DATA after acceptance has no effect on the current frame.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
1. Reset, then Data_Valid=1 for 1 cycle, P_DATA=0xA5, PAR_EN=0, STOP_BITS=1 -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 then idle 1. busy high for exactly 10 cycles. ser_en high for exactly 9 cycles (START + DATA).
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity cycle TX_OUT=0. Repeat with PAR_TYP=1 -> parity cycle TX_OUT=1. Frame is 11 cycles. Repeat with P_DATA=0x01, PAR_TYP=0 -> parity bit 1.
3. Back-to-back: Data_Valid held high with 0x3C then 0xC3, PAR_EN=0 -> second start bit immediately follows the first stop bit. busy never drops. 20 consecutive cycles with both frames correct, LSB first.
4. Data_Valid pulsed with 0xFF during DATA of a 0x00 frame -> 0x00 frame completes unchanged. 0xFF is not sent. Returns to IDLE.
5. rst=0 for 1 cycle in DATA cycle 4 of a 0x55 frame -> at the next edge TX_OUT=1, busy=0, ser_en=0. A new 0x0F request then produces a correct full frame.
6. STOP_BITS=2, PAR_EN=1, PAR_TYP=1, P_DATA=0x80 -> parity bit 0, two stop cycles, frame is 12 cycles.
